alu_exec_unit: RTL

Execution-stage ALU that consumes the 3-bit ALU control code produced by the ALU control decoder, together with two operands. It is the receiving end of the ALU control interface.
- AND/OR/ADD/SUB: registered, 1-cycle latency, one operation accepted per cycle.
- MUL: iterative shift-add multiplier, WIDTH-cycle latency, held off with a ready/valid handshake.
- The pipeline hazard logic uses ready_o to stall the EX stage during a multiply.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_mul_iter.sv | 42 ++++
 rtl/alu_exec_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and execution-unit state type.
// Also used by the ALU control decoder so both ends agree on the codes.
package alu_pkg;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;

  typedef enum logic {
    StIdle,
    StMul
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// done is high in the final iteration; product then carries the completed low WIDTH bits.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;

  assign acc_d   = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign done    = (cnt_q == CNT_W'(1));
  assign product = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= op_a;
      mplier_q <= op_b;
      acc_q    <= '0;
      cnt_q    <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: registered single-cycle logic/arith ops plus a multi-cycle multiply
// that deasserts ready_o while busy so the pipeline can stall EX.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ctrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  alu_state_e       state_q, state_d;
  logic             valid_d, zero_d;
  logic [WIDTH-1:0] data_d, op_result, mul_product;
  logic             mul_start, mul_done;

  alu_mul_iter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mul (
    .clk    (clk_i),
    .rst    (rst_i),
    .start  (mul_start),
    .op_a   (data1_i),
    .op_b   (data2_i),
    .done   (mul_done),
    .product(mul_product)
  );

  assign ready_o = (state_q == StIdle);

  // NOP and reserved codes deliberately produce zero.
  always_comb begin
    op_result = '0;
    case (ctrl_i)
      ALU_AND: op_result = data1_i & data2_i;
      ALU_OR:  op_result = data1_i | data2_i;
      ALU_ADD: op_result = data1_i + data2_i;
      ALU_SUB: op_result = data1_i - data2_i;
      default: op_result = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = 1'b0;
    data_d    = data_o;
    zero_d    = zero_o;
    mul_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (valid_i) begin
          if (ctrl_i == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = StMul;
          end else begin
            data_d  = op_result;
            zero_d  = (op_result == '0);
            valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        if (mul_done) begin
          data_d  = mul_product;
          zero_d  = (mul_product == '0);
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      valid_o <= 1'b0;
      data_o  <= '0;
      zero_o  <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_o <= valid_d;
      data_o  <= data_d;
      zero_o  <= zero_d;
    end
  end

endmodule
